// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with majority sampling and valid/ready output
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_M1   = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_MID  = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] T_SAMP = TW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_DONE,
        S_WAIT
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic                   rx_meta;
    logic                   rxs;
    logic [TW-1:0]          timer;
    logic                   vote0;
    logic                   vote1;
    logic                   maj;
    logic                   sample;
    logic [BW-1:0]          bit_cnt;
    logic                   stop_cnt;
    logic                   stop_last;
    logic [DATA_BITS-1:0]   shreg;
    logic                   perr;
    logic                   ferr;

    // Majority of the two earlier votes and the live sample at the capture point.
    assign maj       = (vote0 & vote1) | (vote0 & rxs) | (vote1 & rxs);
    assign sample    = (timer == T_SAMP);
    assign stop_last = (STOP_BITS == 1) ? 1'b1 : stop_cnt;
    assign o_busy    = (state != S_IDLE);

    // Two-flop synchroniser; rx is asynchronous to clk and idles high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; every bit decision happens at the sample point.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (!rxs) begin
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (sample) begin
                    state_nx = maj ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (sample && (bit_cnt == B_LAST)) begin
                    state_nx = (PARITY != 0) ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                if (sample) begin
                    state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (sample && stop_last) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = rxs ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (rxs) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Bit timer: held at zero while idle so it restarts exactly on entry to START.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if ((state == S_IDLE) || (state == S_WAIT) || (timer == T_LAST)) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Frame datapath: votes, shift register, bit/stop counters and per-word error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vote0    <= 1'b1;
            vote1    <= 1'b1;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            if (timer == T_M1) begin
                vote0 <= rxs;
            end
            if (timer == T_MID) begin
                vote1 <= rxs;
            end
            case (state)
                S_IDLE: begin
                    bit_cnt  <= '0;
                    stop_cnt <= 1'b0;
                    perr     <= 1'b0;
                    ferr     <= 1'b0;
                end
                S_DATA: begin
                    if (sample) begin
                        shreg   <= {maj, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_PAR: begin
                    if (sample) begin
                        perr <= (PARITY == 2) ? ~(^shreg ^ maj) : (^shreg ^ maj);
                    end
                end
                S_STOP: begin
                    if (sample) begin
                        if (!maj) begin
                            ferr <= 1'b1;
                        end
                        stop_cnt <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output word register: deliver in DONE unless a word is still pending, else flag overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            if (o_valid && i_ready) begin
                o_overrun <= 1'b0;
            end
            if (state == S_DONE) begin
                if (!o_valid || i_ready) begin
                    o_data       <= shreg;
                    o_parity_err <= perr;
                    o_frame_err  <= ferr;
                    o_valid      <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
